// File: rtl/boton_debounce_pkg.sv
// Shared types and constants for the button/switch conditioning stage.
// Per-channel FSM encoding and button index assignments for the register bank.
package boton_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

endpackage

// File: rtl/boton_debounce_if.sv
// Raw board inputs and conditioned outputs of the button/switch stage.
// The board/bench side is master, the conditioning block is slave.
interface boton_debounce_if #(
    parameter int N_BITS    = 8,
    parameter int N_BUTTONS = 3
);
    logic [N_BUTTONS-1:0] i_boton;
    logic [N_BITS-1:0]    i_switch;
    logic [N_BUTTONS-1:0] o_pulse;
    logic [N_BUTTONS-1:0] o_level;
    logic [N_BITS-1:0]    o_switch;

    modport master (
        output i_boton, i_switch,
        input  o_pulse, o_level, o_switch
    );

    modport slave (
        input  i_boton, i_switch,
        output o_pulse, o_level, o_switch
    );
endinterface

// File: rtl/boton_debounce_channel.sv
// One debounce channel: 4-state FSM with a stability counter.
// press_event is high in the single cycle the FSM commits to PRESSED from PRESS_WAIT.
module debounce_channel
    import boton_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic sync_i,
    output logic level_o,
    output logic press_event_o
);
    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    db_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // The counter is only reloaded on WAIT entry and stops at CNT_LAST, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_i) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_i)              state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = PRESSED;
                else                      cnt_d   = cnt_q + CNT_BITS'(1);
            end
            PRESSED: begin
                if (!sync_i) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_i)               state_d = PRESSED;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                      cnt_d   = cnt_q + CNT_BITS'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_event_o = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        level_d       = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        level_o       = level_q;
    end
endmodule

// File: rtl/boton_debounce.sv
// Button/switch conditioning ahead of the ALU register bank: sync, debounce, one-hot pulse.
// Optional BOTON_DEBOUNCE_SWITCH_LATCH_EN: o_switch captured only when a pulse is issued.
module boton_debounce
    import boton_debounce_pkg::*;
#(
    parameter int N_BITS          = 8,
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            i_clock,
    input  logic            i_reset,
    boton_debounce_if.slave bus
);
    logic [N_BUTTONS-1:0] boton_meta_q, boton_meta_d;
    logic [N_BUTTONS-1:0] boton_sync_q, boton_sync_d;
    logic [N_BITS-1:0]    switch_meta_q, switch_meta_d;
    logic [N_BITS-1:0]    switch_sync_q, switch_sync_d;
    logic [N_BUTTONS-1:0] pending_q, pending_d;
    logic [N_BUTTONS-1:0] pulse_q, pulse_d;
    logic [N_BUTTONS-1:0] press_event;
    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] grant;

    always_comb begin
        boton_meta_d  = bus.i_boton;
        boton_sync_d  = boton_meta_q;
        switch_meta_d = bus.i_switch;
        switch_sync_d = switch_meta_q;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            boton_meta_q  <= '0;
            boton_sync_q  <= '0;
            switch_meta_q <= '0;
            switch_sync_q <= '0;
            pending_q     <= '0;
            pulse_q       <= '0;
        end else begin
            boton_meta_q  <= boton_meta_d;
            boton_sync_q  <= boton_sync_d;
            switch_meta_q <= switch_meta_d;
            switch_sync_q <= switch_sync_d;
            pending_q     <= pending_d;
            pulse_q       <= pulse_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .i_clock       (i_clock),
                .i_reset       (i_reset),
                .sync_i        (boton_sync_q[gi]),
                .level_o       (level[gi]),
                .press_event_o (press_event[gi])
            );
        end
    endgenerate

    // Arbitrate over already-registered pending bits only; fresh events join next cycle.
    always_comb begin
        grant     = pending_q & (~pending_q + N_BUTTONS'(1));
        pulse_d   = grant;
        pending_d = (pending_q & ~grant) | press_event;
    end

    assign bus.o_pulse = pulse_q;
    assign bus.o_level = level;

`ifdef BOTON_DEBOUNCE_SWITCH_LATCH_EN
    logic [N_BITS-1:0] switch_out_q, switch_out_d;

    always_comb begin
        switch_out_d = (|pulse_d) ? switch_sync_q : switch_out_q;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) switch_out_q <= '0;
        else          switch_out_q <= switch_out_d;
    end

    assign bus.o_switch = switch_out_q;
`else
    assign bus.o_switch = switch_sync_q;
`endif
endmodule

// File: tb/tb_boton_debounce.sv
// Directed bench for boton_debounce with DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_boton_debounce;
    localparam int N_BITS    = 8;
    localparam int N_BUTTONS = 3;
    localparam int DEB       = 4;

    logic i_clock = 1'b0;
    logic i_reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 i_clock = ~i_clock;

    boton_debounce_if #(.N_BITS(N_BITS), .N_BUTTONS(N_BUTTONS)) bus ();

    boton_debounce #(
        .N_BITS         (N_BITS),
        .N_BUTTONS      (N_BUTTONS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance past one rising edge and land on the following falling edge.
    task automatic cyc();
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    initial begin
        i_reset      = 1'b0;
        bus.i_boton  = '0;
        bus.i_switch = '0;
        repeat (3) cyc();
        check("rst_pulse",  32'(bus.o_pulse),  32'h0);
        check("rst_level",  32'(bus.o_level),  32'h0);
        check("rst_switch", 32'(bus.o_switch), 32'h0);

        // Button pressed while reset held: nothing may move.
        bus.i_boton = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check($sformatf("rsthold_pulse[%0d]", k), 32'(bus.o_pulse), 32'h0);
            check($sformatf("rsthold_level[%0d]", k), 32'(bus.o_level), 32'h0);
        end
        bus.i_boton = '0;
        repeat (4) cyc();
        i_reset = 1'b1;
        repeat (2) cyc();

        // Single press on button B: pulse 8 samples after drive (edge E7).
        bus.i_boton = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check($sformatf("pressB_pulse[%0d]", k), 32'(bus.o_pulse), (k == 8) ? 32'h2 : 32'h0);
            check($sformatf("pressB_level[%0d]", k), 32'(bus.o_level), (k >= 7) ? 32'h2 : 32'h0);
        end
        bus.i_boton = '0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("relB_level[%0d]", k), 32'(bus.o_level), (k <= 6) ? 32'h2 : 32'h0);
            check($sformatf("relB_pulse[%0d]", k), 32'(bus.o_pulse), 32'h0);
        end

        // Bouncing button A never stabilises.
        for (int k = 0; k < 18; k++) begin
            bus.i_boton = (k < 12 && (k % 2) == 0) ? 3'b001 : 3'b000;
            cyc();
            check($sformatf("bounce_pulse[%0d]", k), 32'(bus.o_pulse), 32'h0);
            check($sformatf("bounce_level[%0d]", k), 32'(bus.o_level), 32'h0);
        end

        // Simultaneous A and OP: A first, OP next cycle.
        bus.i_boton = 3'b101;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            check($sformatf("dual_pulse[%0d]", k), 32'(bus.o_pulse),
                  (k == 8) ? 32'h1 : (k == 9) ? 32'h4 : 32'h0);
        end
        bus.i_boton = '0;
        repeat (10) cyc();
        check("dual_idle_level", 32'(bus.o_level), 32'h0);

        // Reset two cycles into PRESS_WAIT with button held through release.
        bus.i_boton = 3'b001;
        repeat (4) cyc();
        i_reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check($sformatf("midrst_pulse[%0d]", k), 32'(bus.o_pulse), 32'h0);
            check($sformatf("midrst_level[%0d]", k), 32'(bus.o_level), 32'h0);
        end
        i_reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("postrst_pulse[%0d]", k), 32'(bus.o_pulse), (k == 8) ? 32'h1 : 32'h0);
        end
        bus.i_boton = '0;
        repeat (10) cyc();

`ifdef BOTON_DEBOUNCE_SWITCH_LATCH_EN
        bus.i_switch = 8'hA5;
        repeat (3) cyc();
        check("latch_pre", 32'(bus.o_switch), 32'h0);
        bus.i_boton = 3'b010;
        repeat (7) cyc();
        check("latch_pre_pulse", 32'(bus.o_switch), 32'h0);
        cyc();
        check("latch_pulse", 32'(bus.o_pulse), 32'h2);
        check("latch_cap", 32'(bus.o_switch), 32'hA5);
        bus.i_switch = 8'h3C;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check($sformatf("latch_hold[%0d]", k), 32'(bus.o_switch), 32'hA5);
        end
        bus.i_boton = '0;
        repeat (10) cyc();
`else
        bus.i_switch = 8'hA5;
        cyc();
        check("sw_lat1", 32'(bus.o_switch), 32'h00);
        cyc();
        check("sw_lat2", 32'(bus.o_switch), 32'hA5);
        bus.i_switch = 8'h3C;
        cyc();
        check("sw_chg1", 32'(bus.o_switch), 32'hA5);
        cyc();
        check("sw_chg2", 32'(bus.o_switch), 32'h3C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
